vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, vertical widths in lines.
REQ-004 SHALL have parameters H_SYNC_POL and V_SYNC_POL, default 0, sync asserted level (0 = active-low).
REQ-005 SHALL have parameter PIX_DIV, default 1, which gives clk cycles per pixel (at least 1).
REQ-006 SHALL have parameter FRAME_CNT_W, default 8, frame counter width.
REQ-007 Ports: clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-008 Ports: i_en  in  1  run enable; low freezes timing.
REQ-009 Ports: o_pix_ce  out  1  one-cycle pulse in the first clk of each new pixel.
REQ-010 Ports: o_draw_active  out  1  current pixel inside the active area.
REQ-011 Ports: o_active_x  out  $clog2(H_ACTIVE)  and o_active_y  out  $clog2(V_ACTIVE)  active coordinates, 0 outside the active area.
REQ-012 Ports: o_h_sync, o_v_sync  out  1  sync outputs at the configured polarity.
REQ-013 Ports: o_line_start, o_frame_start  out  1  pulses marking pixel x=0 and pixel (0,0).
REQ-014 Ports: o_frame_cnt  out  FRAME_CNT_W  frames started, present only with VGA_TIMING_FRAME_CNT_EN.

Function
REQ-015 SHALL derive H_TOTAL as the sum of the four H parameters and V_TOTAL as the sum of the four V parameters, with internal counters x, y of widths $clog2(H_TOTAL) and $clog2(V_TOTAL).
REQ-016 SHALL run a divider d over 0..PIX_DIV-1, advancing only while i_en=1, with tick = i_en & (d==PIX_DIV-1); with PIX_DIV=1, tick = i_en.
REQ-017 On tick, x SHALL increment; at H_TOTAL-1, x SHALL wrap to 0 and y SHALL increment, wrapping from V_TOTAL-1 to 0; wrap SHALL use explicit compares, never overflow.
REQ-018 All outputs SHALL be registered and SHALL update on the same edge as x and y, reflecting the new (x,y).
REQ-019 o_draw_active SHALL be high when x<H_ACTIVE and y<V_ACTIVE, and o_active_x and o_active_y SHALL be 0 when it is low.
REQ-020 o_h_sync SHALL equal H_SYNC_POL when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, else its inverse; o_v_sync SHALL follow the same rule on y with V_SYNC_POL.
REQ-021 o_pix_ce SHALL be high for exactly the one clk following each tick; o_line_start SHALL equal o_pix_ce & x==0, and o_frame_start SHALL equal o_pix_ce & x==0 & y==0.
REQ-022 While i_en=0, d, x, y and all level outputs SHALL hold, and all pulse outputs SHALL be 0; on re-enable, d SHALL resume from its held value.

Reset
REQ-023 Reset SHALL set d=0, x=H_TOTAL-1 and y=V_TOTAL-1, so the first tick presents (0,0) together with o_frame_start.
REQ-024 Reset SHALL drive outputs to: o_draw_active 0, o_active_x/o_active_y 0, syncs inactive, all pulses 0, o_frame_cnt 0.
REQ-025 Reset asserted mid-frame SHALL return all state to REQ-023 and REQ-024 immediately, without waiting for clk.

Configuration
REQ-026 With macro VGA_TIMING_FRAME_CNT_EN defined, o_frame_cnt SHALL increment, wrapping modulo 2^FRAME_CNT_W, on the same edge that raises o_frame_start, so it equals 1 during the first frame after reset.
REQ-027 Without VGA_TIMING_FRAME_CNT_EN, the o_frame_cnt port and its register SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-028 Default parameters with PIX_DIV=4, release reset, i_en=1 -> first o_pix_ce in clk 4, with o_frame_start=1, o_line_start=1, draw_active=1, x=0, y=0; o_pix_ce period thereafter 4 clk.
REQ-029 Default parameters with PIX_DIV=1 -> o_h_sync low for exactly 96 pixels (x 656..751), line period 800 clk, o_v_sync low for 2 lines (y 490..491), frame period 420000 clk.
REQ-030 H=4/1/1/1, V=2/1/1/1, PIX_DIV=1, H_SYNC_POL=1 -> x sequence 0..6 then 0, y wraps after 4, h_sync high only at x=5, draw_active for 8 of 35 pixels.
REQ-031 i_en dropped for 10 clk at x=100 -> x, y and syncs held, no pulses; after re-enable, next pixel is x=101 with no skipped or repeated pixel.
REQ-032 rst pulsed mid-line at y=200 -> outputs match REQ-024 asynchronously, and the next frame starts at (0,0) with o_frame_start.
REQ-033 With VGA_TIMING_FRAME_CNT_EN and FRAME_CNT_W=2, small geometry, run 5 frames -> o_frame_cnt sequence 1,2,3,0,1, each step coincident with o_frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, x/y raster counters and
// registered sync/active/pulse outputs. Optional macro: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int PIX_DIV     = 1,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_en,
    output logic                        o_pix_ce,
    output logic                        o_draw_active,
    output logic [$clog2(H_ACTIVE)-1:0] o_active_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_active_y,
    output logic                        o_h_sync,
    output logic                        o_v_sync,
    output logic                        o_line_start,
    output logic                        o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0]      o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int AXW     = $clog2(H_ACTIVE);
    localparam int AYW     = $clog2(V_ACTIVE);

    localparam logic [DW-1:0] D_MAX  = DW'(PIX_DIV - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(V_TOTAL - 1);
    // one extra bit so sync end == total still fits
    localparam logic [XW:0]   H_ACT  = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0]   HS_BEG = (XW+1)'(H_ACTIVE + H_FRONT);
    localparam logic [XW:0]   HS_END = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [YW:0]   V_ACT  = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0]   VS_BEG = (YW+1)'(V_ACTIVE + V_FRONT);
    localparam logic [YW:0]   VS_END = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic          HP     = 1'(H_SYNC_POL);
    localparam logic          VP     = 1'(V_SYNC_POL);

    logic [DW-1:0] r_d;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_tick;
    logic          w_act;
    logic          w_hs_in;
    logic          w_vs_in;
    logic          w_origin;

    assign w_tick = i_en & (r_d == D_MAX);

    // next raster position and its decoded properties
    always_comb begin
        w_nx = r_x;
        w_ny = r_y;
        if (r_x == X_MAX) begin
            w_nx = '0;
            w_ny = (r_y == Y_MAX) ? '0 : r_y + 1'b1;
        end else begin
            w_nx = r_x + 1'b1;
        end
        w_act    = ({1'b0, w_nx} < H_ACT) && ({1'b0, w_ny} < V_ACT);
        w_hs_in  = ({1'b0, w_nx} >= HS_BEG) && ({1'b0, w_nx} < HS_END);
        w_vs_in  = ({1'b0, w_ny} >= VS_BEG) && ({1'b0, w_ny} < VS_END);
        w_origin = (w_nx == '0) && (w_ny == '0);
    end

    // pixel divider, advances only while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d <= '0;
        end else if (i_en) begin
            r_d <= (r_d == D_MAX) ? '0 : r_d + 1'b1;
        end
    end

    // raster counters and registered outputs, updated together on tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= X_MAX;
            r_y           <= Y_MAX;
            o_pix_ce      <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_draw_active <= 1'b0;
            o_active_x    <= '0;
            o_active_y    <= '0;
            o_h_sync      <= ~HP;
            o_v_sync      <= ~VP;
        end else begin
            o_pix_ce      <= w_tick;
            o_line_start  <= w_tick & (w_nx == '0);
            o_frame_start <= w_tick & w_origin;
            if (w_tick) begin
                r_x           <= w_nx;
                r_y           <= w_ny;
                o_draw_active <= w_act;
                o_active_x    <= w_act ? w_nx[AXW-1:0] : '0;
                o_active_y    <= w_act ? w_ny[AYW-1:0] : '0;
                o_h_sync      <= w_hs_in ? HP : ~HP;
                o_v_sync      <= w_vs_in ? VP : ~VP;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // frames started, bumped on the edge that raises o_frame_start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_frame_cnt <= '0;
        end else if (w_tick && w_origin) begin
            o_frame_cnt <= o_frame_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default geometry at PIX_DIV=4 and a tiny 7x5 raster
// at PIX_DIV=1 with positive h-sync; frame counter when the macro is set.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       a_rst, a_en, a_pce, a_draw, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_ax;
    logic [8:0] a_ay;
    logic       b_rst, b_en, b_pce, b_draw, b_hs, b_vs, b_ls, b_fs;
    logic [1:0] b_ax;
    logic [0:0] b_ay;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] a_fc;
    logic [1:0] b_fc;
    int fc_exp [5] = '{1, 2, 3, 0, 1};
`endif

    vga_timing_gen #(.PIX_DIV(4)) u_a (
        .clk           (clk),
        .rst           (a_rst),
        .i_en          (a_en),
        .o_pix_ce      (a_pce),
        .o_draw_active (a_draw),
        .o_active_x    (a_ax),
        .o_active_y    (a_ay),
        .o_h_sync      (a_hs),
        .o_v_sync      (a_vs),
        .o_line_start  (a_ls),
        .o_frame_start (a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt   (a_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1), .PIX_DIV(1), .FRAME_CNT_W(2)
    ) u_b (
        .clk           (clk),
        .rst           (b_rst),
        .i_en          (b_en),
        .o_pix_ce      (b_pce),
        .o_draw_active (b_draw),
        .o_active_x    (b_ax),
        .o_active_y    (b_ay),
        .o_h_sync      (b_hs),
        .o_v_sync      (b_vs),
        .o_line_start  (b_ls),
        .o_frame_start (b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .o_frame_cnt   (b_fc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int xx;
        int cnt;
        int first;
        int done;
        int ex;
        int ey;
        int act;
        int nd;
        int nh;
        int k;

        a_rst = 1'b0; a_en = 1'b0;
        b_rst = 1'b0; b_en = 1'b0;
        #2;
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        chk("a_rst_ce",    32'(a_pce),  0);
        chk("a_rst_draw",  32'(a_draw), 0);
        chk("a_rst_ax",    32'(a_ax),   0);
        chk("a_rst_ay",    32'(a_ay),   0);
        chk("a_rst_hs",    32'(a_hs),   1);
        chk("a_rst_vs",    32'(a_vs),   1);
        chk("a_rst_ls",    32'(a_ls),   0);
        chk("a_rst_fs",    32'(a_fs),   0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("a_rst_fc",    32'(a_fc),   0);
`endif

        // release A, first pixel in clk 4
        @(posedge clk);
        #1;
        a_rst = 1'b0; a_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("a_pre_ce", 32'(a_pce), 0);
        end
        step(1);
        chk("a_first_ce",   32'(a_pce),  1);
        chk("a_first_fs",   32'(a_fs),   1);
        chk("a_first_ls",   32'(a_ls),   1);
        chk("a_first_draw", 32'(a_draw), 1);
        chk("a_first_ax",   32'(a_ax),   0);
        chk("a_first_ay",   32'(a_ay),   0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("a_gap_ce", 32'(a_pce), 0);
        end
        step(1);
        chk("a_px1_ce", 32'(a_pce), 1);
        chk("a_px1_ax", 32'(a_ax),  1);
        chk("a_px1_fs", 32'(a_fs),  0);
        chk("a_px1_ls", 32'(a_ls),  0);

        // advance to x=100 then freeze mid-divider
        step(4 * 99);
        chk("a_x100_ax", 32'(a_ax),  100);
        chk("a_x100_ce", 32'(a_pce), 1);
        step(2);
        chk("a_mid_ce", 32'(a_pce), 0);
        a_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("a_hold_ce",   32'(a_pce),  0);
            chk("a_hold_ls",   32'(a_ls),   0);
            chk("a_hold_ax",   32'(a_ax),   100);
            chk("a_hold_ay",   32'(a_ay),   0);
            chk("a_hold_hs",   32'(a_hs),   1);
            chk("a_hold_draw", 32'(a_draw), 1);
        end
        a_en = 1'b1;
        step(1);
        chk("a_resume_ce0", 32'(a_pce), 0);
        chk("a_resume_ax0", 32'(a_ax),  100);
        step(1);
        chk("a_resume_ce1", 32'(a_pce), 1);
        chk("a_resume_ax1", 32'(a_ax),  101);

        // walk the rest of the line measuring h-sync
        xx = 101; cnt = 0; first = -1; done = 0;
        for (int s = 0; s < 1000 && done == 0; s++) begin
            step(4);
            xx++;
            chk("a_ce_period", 32'(a_pce), 1);
            if (a_ls === 1'b1) begin
                done = 1;
            end else if (a_hs === 1'b0) begin
                if (first < 0) first = xx;
                cnt++;
            end
        end
        chk("a_line_seen",   32'(done),   1);
        chk("a_hs_first_x",  32'(first),  656);
        chk("a_hs_width",    32'(cnt),    96);
        chk("a_line_len",    32'(xx),     800);
        chk("a_line2_ay",    32'(a_ay),   1);
        chk("a_line2_draw",  32'(a_draw), 1);
        chk("a_line2_hs",    32'(a_hs),   1);
        chk("a_line2_vs",    32'(a_vs),   1);

        // async reset of A mid-frame (pulses and draw are high here)
        #2;
        a_rst = 1'b1;
        #1;
        chk("a_arst_ce",   32'(a_pce),  0);
        chk("a_arst_ls",   32'(a_ls),   0);
        chk("a_arst_draw", 32'(a_draw), 0);
        chk("a_arst_ay",   32'(a_ay),   0);

        // tiny raster: 5 frames of 7x5
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_en = 1'b1;
        nd = 0; nh = 0; k = 0;
        for (int i = 0; i < 175; i++) begin
            step(1);
            ex  = i % 7;
            ey  = (i / 7) % 5;
            act = (ex < 4 && ey < 2) ? 1 : 0;
            chk("b_ce",   32'(b_pce),  1);
            chk("b_draw", 32'(b_draw), 32'(act));
            chk("b_ax",   32'(b_ax),   (act != 0) ? 32'(ex) : 0);
            chk("b_ay",   32'(b_ay),   (act != 0) ? 32'(ey) : 0);
            chk("b_hs",   32'(b_hs),   32'(ex == 5));
            chk("b_vs",   32'(b_vs),   32'(ey != 3));
            chk("b_ls",   32'(b_ls),   32'(ex == 0));
            chk("b_fs",   32'(b_fs),   32'(ex == 0 && ey == 0));
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (ex == 0 && ey == 0) begin
                chk("b_fc_step", 32'(b_fc), 32'(fc_exp[k]));
                k++;
            end
`endif
            if (i < 35) begin
                if (b_draw === 1'b1) nd++;
                if (b_hs === 1'b1) nh++;
            end
        end
        chk("b_draw_count", 32'(nd), 8);
        chk("b_hs_count",   32'(nh), 5);

        // reset B mid-line at (2,1)
        step(10);
        chk("b_pre_draw", 32'(b_draw), 1);
        chk("b_pre_ax",   32'(b_ax),   2);
        chk("b_pre_ay",   32'(b_ay),   1);
        #2;
        b_rst = 1'b1;
        #1;
        chk("b_arst_draw", 32'(b_draw), 0);
        chk("b_arst_ax",   32'(b_ax),   0);
        chk("b_arst_ay",   32'(b_ay),   0);
        chk("b_arst_hs",   32'(b_hs),   0);
        chk("b_arst_vs",   32'(b_vs),   1);
        chk("b_arst_ce",   32'(b_pce),  0);
        chk("b_arst_ls",   32'(b_ls),   0);
        chk("b_arst_fs",   32'(b_fs),   0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("b_arst_fc",   32'(b_fc),   0);
`endif
        #1;
        b_rst = 1'b0;
        step(1);
        chk("b_post_fs",   32'(b_fs),   1);
        chk("b_post_ls",   32'(b_ls),   1);
        chk("b_post_draw", 32'(b_draw), 1);
        chk("b_post_ax",   32'(b_ax),   0);
        chk("b_post_ay",   32'(b_ay),   0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("b_post_fc",   32'(b_fc),   1);
`endif
        step(1);
        chk("b_post2_ax",  32'(b_ax),   1);
        chk("b_post2_fs",  32'(b_fs),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
